mem_apb_arbiter: RTL and testbench

- Shares one APB memory port between the core's instruction-fetch APB master and data-memory APB master (unified memory build).
- Sits between the core's imem/dmem APB master ports and a single APB memory slave.
- Each core-side port looks like an APB slave. Arbitration is round-robin with a registered grant and a 3-state APB sequencer.

---
 rtl/mem_apb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_apb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_apb_arbiter.sv
// Round-robin arbiter sharing one APB memory slave between the imem (read-only) and dmem requesters.
// Optional ACCESS-phase watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_apb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic [ADDR_W-1:0]   i_paddr,
  output logic                i_pready,
  output logic [DATA_W-1:0]   i_prdata,
  output logic                i_pslverr,
  input  logic                d_psel,
  input  logic                d_penable,
  input  logic                d_pwrite,
  input  logic [ADDR_W-1:0]   d_paddr,
  input  logic [DATA_W-1:0]   d_pwdata,
  input  logic [DATA_W/8-1:0] d_pstrb,
  output logic                d_pready,
  output logic [DATA_W-1:0]   d_prdata,
  output logic                d_pslverr,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pstrb,
  input  logic [DATA_W-1:0]   m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic       GNT_IMEM  = 1'b0;
  localparam logic       GNT_DMEM  = 1'b1;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              grant_r;
  logic              grant_nxt_s;
  logic              last_grant_r;
  logic              last_grant_nxt_s;
  logic              active_s;
  logic              complete_s;
  logic              timeout_s;
  logic              other_psel_s;
  logic [DATA_W-1:0] rdata_s;
  logic              err_s;

  // Penable from the requesters carries no information the arbiter needs.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_penable, d_penable};

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: cleared in SETUP, counts ACCESS cycles the slave leaves unanswered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_SETUP) begin
      cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && !m_pready && !timeout_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A real slave answer on the limit cycle takes precedence over the forced error.
  assign timeout_s = (state_r == ST_ACCESS) && !m_pready && (cnt_r == CNT_W'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  assign active_s     = (state_r != ST_IDLE);
  assign complete_s   = (state_r == ST_ACCESS) && (m_pready || timeout_s);
  assign other_psel_s = (grant_r == GNT_IMEM) ? d_psel : i_psel;

  // Sequencer and round-robin grant selection
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (i_psel && d_psel) begin
          grant_nxt_s = ~last_grant_r;
          state_nxt_s = ST_SETUP;
        end else if (d_psel) begin
          grant_nxt_s = GNT_DMEM;
          state_nxt_s = ST_SETUP;
        end else if (i_psel) begin
          grant_nxt_s = GNT_IMEM;
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (complete_s) begin
          last_grant_nxt_s = grant_r;
          if (other_psel_s) begin
            grant_nxt_s = ~grant_r;
            state_nxt_s = ST_SETUP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, grant and fairness history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= GNT_IMEM;
      last_grant_r <= GNT_IMEM;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  assign m_psel    = active_s;
  assign m_penable = (state_r == ST_ACCESS);
  assign m_paddr   = !active_s ? '0 : ((grant_r == GNT_DMEM) ? d_paddr : i_paddr);
  assign m_pwrite  = active_s && (grant_r == GNT_DMEM) && d_pwrite;
  assign m_pwdata  = (active_s && (grant_r == GNT_DMEM)) ? d_pwdata : '0;
  assign m_pstrb   = (active_s && (grant_r == GNT_DMEM)) ? d_pstrb : '0;

  assign rdata_s   = timeout_s ? '0 : m_prdata;
  assign err_s     = m_pslverr || timeout_s;

  assign i_pready  = complete_s && (grant_r == GNT_IMEM);
  assign i_prdata  = i_pready ? rdata_s : '0;
  assign i_pslverr = i_pready && err_s;
  assign d_pready  = complete_s && (grant_r == GNT_DMEM);
  assign d_prdata  = d_pready ? rdata_s : '0;
  assign d_pslverr = d_pready && err_s;

endmodule

// File: tb/tb_mem_apb_arbiter.sv
// Scoreboard bench for mem_apb_arbiter: directed requests, monitor pops expected completions on pready.
module tb_mem_apb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk;
  logic          rst;
  logic          i_psel, i_penable, i_pready, i_pslverr;
  logic [AW-1:0] i_paddr;
  logic [DW-1:0] i_prdata;
  logic          d_psel, d_penable, d_pwrite, d_pready, d_pslverr;
  logic [AW-1:0] d_paddr;
  logic [DW-1:0] d_pwdata, d_prdata;
  logic [3:0]    d_pstrb;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic [3:0]    m_pstrb;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } dreq_t;

  exp_t        sb[$];
  logic [31:0] iq[$];
  dreq_t       dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int i_cnt = 0;
  int d_cnt = 0;
  bit i_done = 1'b0;
  bit d_done = 1'b0;
  int slv_waits = 0;
  bit slv_err = 1'b0;
  bit slv_never = 1'b0;
  int acc_cnt = 0;

  mem_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_psel(i_psel), .i_penable(i_penable), .i_paddr(i_paddr),
    .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr),
    .d_psel(d_psel), .d_penable(d_penable), .d_pwrite(d_pwrite), .d_paddr(d_paddr),
    .d_pwdata(d_pwdata), .d_pstrb(d_pstrb),
    .d_pready(d_pready), .d_prdata(d_prdata), .d_pslverr(d_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.port = p;
    x.data = d;
    x.err  = e;
    x.cyc  = c;
    return x;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d completions outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Slave model: returns paddr + 0x83 after slv_waits ACCESS cycles
  initial begin
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (m_psel && m_penable) begin
        m_pready = !slv_never && (acc_cnt == slv_waits);
        acc_cnt++;
      end else begin
        m_pready = 1'b0;
        acc_cnt = 0;
      end
      m_prdata  = m_pready ? (m_paddr + 32'h0000_0083) : 32'h0;
      m_pslverr = m_pready && slv_err;
    end
  end

  // Imem requester: holds psel until pready, then takes the next queued address
  initial begin
    i_psel = 1'b0; i_penable = 1'b0; i_paddr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        i_psel = 1'b0; i_penable = 1'b0; i_paddr = '0; i_done = 1'b0; iq.delete();
      end else begin
        if (i_done) begin
          i_done = 1'b0; i_psel = 1'b0; i_penable = 1'b0; i_paddr = '0;
        end
        if (i_psel) i_penable = 1'b1;
        else if (iq.size() > 0) begin
          i_paddr = iq.pop_front(); i_psel = 1'b1; i_penable = 1'b0;
        end
      end
    end
  end

  initial begin
    dreq_t r;
    d_psel = 1'b0; d_penable = 1'b0; d_pwrite = 1'b0; d_paddr = '0; d_pwdata = '0; d_pstrb = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        d_psel = 1'b0; d_penable = 1'b0; d_pwrite = 1'b0; d_paddr = '0; d_pwdata = '0; d_pstrb = '0;
        d_done = 1'b0; dq.delete();
      end else begin
        if (d_done) begin
          d_done = 1'b0; d_psel = 1'b0; d_penable = 1'b0;
        end
        if (d_psel) d_penable = 1'b1;
        else if (dq.size() > 0) begin
          r = dq.pop_front();
          d_pwrite = r.wr; d_paddr = r.addr; d_pwdata = r.wdata; d_pstrb = r.strb;
          d_psel = 1'b1; d_penable = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic        mp, me, oe;
    logic [31:0] md, od;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (i_pready || d_pready) begin
        if (i_pready && d_pready) begin
          errors++;
          $display("FAIL both_pready: got i_pready=1 d_pready=1, expected at most one");
        end
        mp = d_pready;
        md = mp ? d_prdata : i_prdata;
        me = mp ? d_pslverr : i_pslverr;
        od = mp ? i_prdata : d_prdata;
        oe = mp ? i_pslverr : d_pslverr;
        if (i_pready) begin i_done = 1'b1; i_cnt++; end
        if (d_pready) begin d_done = 1'b1; d_cnt++; end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready: got port %0d data %h at cycle %0d, expected no completion", mp, md, cyc);
        end else begin
          e = sb.pop_front();
          if (mp !== e.port || md !== e.data || me !== e.err || cyc != e.cyc || od !== 32'h0 || oe !== 1'b0) begin
            errors++;
            $display("FAIL completion: got port %0d data %h err %0b cycle %0d other %h/%0b, expected port %0d data %h err %0b cycle %0d other 0/0",
                     mp, md, me, cyc, od, oe, e.port, e.data, e.err, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c, ic0, dc0;
    dreq_t r;
    rst = 1'b1;
    #12;
    chk("rst_psel", 32'(m_psel), 32'h0);
    chk("rst_penable", 32'(m_penable), 32'h0);
    chk("rst_paddr", m_paddr, 32'h0);
    chk("rst_preadys", 32'({i_pready, d_pready}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Imem-only read, zero-wait slave
    @(negedge clk); c = cyc;
    sb.push_back(mk(1'b0, 32'h0000_0093, 1'b0, c + 3));
    iq.push_back(32'h0000_0010);
    @(negedge clk);
    chk("t1_psel_req_cycle", 32'(m_psel), 32'h0);
    @(negedge clk);
    chk("t1_setup_psel", 32'(m_psel), 32'h1);
    chk("t1_setup_penable", 32'(m_penable), 32'h0);
    chk("t1_setup_paddr", m_paddr, 32'h0000_0010);
    chk("t1_setup_pwrite", 32'(m_pwrite), 32'h0);
    @(negedge clk);
    chk("t1_access_penable", 32'(m_penable), 32'h1);
    chk("t1_access_pwdata", m_pwdata, 32'h0);
    wait_drain();

    // Tie straight after reset: dmem first, then imem
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); c = cyc;
    sb.push_back(mk(1'b1, 32'h0000_2083, 1'b0, c + 3));
    sb.push_back(mk(1'b0, 32'h0000_0183, 1'b0, c + 5));
    r.wr = 1'b1; r.addr = 32'h0000_2000; r.wdata = 32'hDEAD_BEEF; r.strb = 4'hF;
    dq.push_back(r);
    iq.push_back(32'h0000_0100);
    repeat (2) @(negedge clk);
    chk("t2_d_pwrite", 32'(m_pwrite), 32'h1);
    chk("t2_d_paddr", m_paddr, 32'h0000_2000);
    chk("t2_d_pwdata", m_pwdata, 32'hDEAD_BEEF);
    chk("t2_d_pstrb", 32'(m_pstrb), 32'hF);
    repeat (2) @(negedge clk);
    chk("t2_i_setup_psel", 32'(m_psel), 32'h1);
    chk("t2_i_setup_penable", 32'(m_penable), 32'h0);
    chk("t2_i_paddr", m_paddr, 32'h0000_0100);
    chk("t2_i_pwrite", 32'(m_pwrite), 32'h0);
    chk("t2_i_pwdata", m_pwdata, 32'h0);
    chk("t2_i_pstrb", 32'(m_pstrb), 32'h0);
    wait_drain();

    // Continuous requests from both ports: strict alternation, no idle cycles
    ic0 = i_cnt; dc0 = d_cnt;
    @(negedge clk); c = cyc;
    for (int k = 0; k < 4; k++) begin
      r.wr = 1'b0; r.addr = 32'h0000_3000 + 32'(4 * k); r.wdata = 32'h0; r.strb = 4'h0;
      dq.push_back(r);
      iq.push_back(32'h0000_0400 + 32'(4 * k));
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(1'b1, 32'h0000_3083 + 32'(4 * k), 1'b0, c + 3 + 4 * k));
      sb.push_back(mk(1'b0, 32'h0000_0483 + 32'(4 * k), 1'b0, c + 5 + 4 * k));
    end
    wait_drain();
    chk("t3_i_pulses", 32'(i_cnt - ic0), 32'd4);
    chk("t3_d_pulses", 32'(d_cnt - dc0), 32'd4);

    // Dmem read with 3 wait states and slave error
    slv_waits = 3; slv_err = 1'b1;
    @(negedge clk); c = cyc;
    sb.push_back(mk(1'b1, 32'h0000_00C7, 1'b1, c + 6));
    r.wr = 1'b0; r.addr = 32'h0000_0044; r.wdata = 32'h0; r.strb = 4'h0;
    dq.push_back(r);
    repeat (5) @(negedge clk);
    chk("t4_wait_penable", 32'(m_penable), 32'h1);
    chk("t4_wait_d_pready", 32'(d_pready), 32'h0);
    wait_drain();
    slv_waits = 0; slv_err = 1'b0;

    // Reset during ACCESS of a dmem write, then an uncontested imem read
    slv_waits = 5;
    @(negedge clk);
    r.wr = 1'b1; r.addr = 32'h0000_0500; r.wdata = 32'h1234_5678; r.strb = 4'h3;
    dq.push_back(r);
    repeat (3) @(negedge clk);
    chk("t5_pre_rst_penable", 32'(m_penable), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_psel", 32'(m_psel), 32'h0);
    chk("t5_rst_penable", 32'(m_penable), 32'h0);
    chk("t5_rst_pwrite", 32'(m_pwrite), 32'h0);
    chk("t5_rst_paddr", m_paddr, 32'h0);
    chk("t5_rst_pwdata", m_pwdata, 32'h0);
    chk("t5_rst_pstrb", 32'(m_pstrb), 32'h0);
    chk("t5_rst_d_pready", 32'(d_pready), 32'h0);
    @(negedge clk); rst = 1'b0; slv_waits = 0;
    @(negedge clk); c = cyc;
    sb.push_back(mk(1'b0, 32'h0000_0683, 1'b0, c + 3));
    iq.push_back(32'h0000_0600);
    wait_drain();

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: watchdog forces an error completion
    slv_never = 1'b1;
    @(negedge clk); c = cyc;
    sb.push_back(mk(1'b0, 32'h0, 1'b1, c + 7));
    iq.push_back(32'h0000_0700);
    repeat (7) @(negedge clk);
    chk("t6_timeout_psel", 32'(m_psel), 32'h1);
    @(negedge clk);
    chk("t6_after_psel", 32'(m_psel), 32'h0);
    chk("t6_after_penable", 32'(m_penable), 32'h0);
    wait_drain();
    slv_never = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
